// File: rtl/demux_stream_if.sv
// Handshake bundle for demux_stream: one producer-side port and NUM_OUT consumer channels.
// The master modport is the demultiplexer itself; slave is the surrounding producer/consumers.
interface demux_stream_if #(
  parameter int DATA_BITS = 32,
  parameter int OUT_BITS  = 32,
  parameter int NUM_OUT   = 4,
  parameter int CNT_BITS  = 8,
  parameter int SEL_BITS  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);

  logic [DATA_BITS-1:0]        in_data;
  logic [SEL_BITS-1:0]         in_sel;
  logic                        in_bcast;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_OUT*OUT_BITS-1:0] out_data;
  logic [NUM_OUT-1:0]          out_valid;
  logic [NUM_OUT-1:0]          out_ready;
  logic [CNT_BITS-1:0]         drop_count;

  modport master (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_count
  );

  modport slave (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_count
  );

endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_OUT stream demultiplexer with a one-entry holding register per channel.
// Optional broadcast to all channels is enabled by defining DEMUX_BROADCAST_EN.
module demux_stream #(
  parameter int DATA_BITS = 32,
  parameter int OUT_BITS  = 32,
  parameter int NUM_OUT   = 4,
  parameter int CNT_BITS  = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  demux_stream_if.master bus
);

  localparam int SEL_BITS = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic [NUM_OUT-1:0]  full_q;
  logic [NUM_OUT-1:0]  full_d;
  logic [OUT_BITS-1:0] data_q [NUM_OUT];
  logic [OUT_BITS-1:0] data_d [NUM_OUT];
  logic [CNT_BITS-1:0] drop_q;
  logic [CNT_BITS-1:0] drop_d;

  logic [NUM_OUT-1:0]  can_load;
  logic [NUM_OUT-1:0]  sel_hit;
  logic [NUM_OUT-1:0]  load;
  logic                sel_ok;
  logic                bcast;
  logic                accept;

  // A channel can take a word if it is empty or its consumer drains this cycle.
  assign can_load = ~full_q | bus.out_ready;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = bus.in_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = bus.in_bcast;
  assign bcast        = 1'b0;
`endif

  if (OUT_BITS < DATA_BITS) begin : g_trunc
    logic unused_hi;
    assign unused_hi = |bus.in_data[DATA_BITS-1:OUT_BITS];
  end

  always_comb begin
    sel_hit = '0;
    sel_ok  = (int'(bus.in_sel) < NUM_OUT);
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = sel_ok && (bus.in_sel == SEL_BITS'(i));
    end
  end

  // Ready never depends on in_valid; out-of-range selectors are always swallowed.
  always_comb begin
    if (bcast) begin
      bus.in_ready = &can_load;
    end else if (!sel_ok) begin
      bus.in_ready = 1'b1;
    end else begin
      bus.in_ready = |(sel_hit & can_load);
    end
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    load   = '0;
    full_d = '0;
    drop_d = drop_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      load[i]   = accept && (bcast || sel_hit[i]);
      full_d[i] = load[i] || (full_q[i] && !bus.out_ready[i]);
      data_d[i] = load[i] ? bus.in_data[OUT_BITS-1:0] : data_q[i];
    end
    if (accept && !bcast && !sel_ok && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      drop_q <= drop_d;
      for (int i = 0; i < NUM_OUT; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      bus.out_data[i*OUT_BITS +: OUT_BITS] = data_q[i];
    end
  end

  assign bus.out_valid  = full_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic against an occupancy model.
// Instance A is 4 channels / 8-bit counter, instance B is 3 channels / 2-bit counter for drop saturation.
module tb_demux_stream;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] stimData  = '0;
  logic [1:0]  stimSel   = '0;
  logic        stimBcast = 1'b0;
  logic        stimValid = 1'b0;
  logic [3:0]  stimReady = '0;

  demux_stream_if #(.DATA_BITS(32), .OUT_BITS(16), .NUM_OUT(4), .CNT_BITS(8)) busA ();
  demux_stream_if #(.DATA_BITS(32), .OUT_BITS(16), .NUM_OUT(3), .CNT_BITS(2)) busB ();

  assign busA.in_data   = stimData;
  assign busA.in_sel    = stimSel;
  assign busA.in_bcast  = stimBcast;
  assign busA.in_valid  = stimValid;
  assign busA.out_ready = stimReady;
  assign busB.in_data   = stimData;
  assign busB.in_sel    = stimSel;
  assign busB.in_bcast  = stimBcast;
  assign busB.in_valid  = stimValid;
  assign busB.out_ready = stimReady[2:0];

  demux_stream #(.DATA_BITS(32), .OUT_BITS(16), .NUM_OUT(4), .CNT_BITS(8)) dutA (
    .clock(clock), .reset_n(reset_n), .bus(busA));
  demux_stream #(.DATA_BITS(32), .OUT_BITS(16), .NUM_OUT(3), .CNT_BITS(2)) dutB (
    .clock(clock), .reset_n(reset_n), .bus(busB));

  // Reference: each channel is a single-slot mailbox; index 0 models dutA, 1 models dutB.
  bit          modelHas  [2][4];
  logic [15:0] modelWord [2][4];
  int          modelDrops[2];
  int          checks = 0;
  int          errors = 0;

  function automatic int numOut(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int dropMax(int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic bit modelReady(int k);
`ifdef DEMUX_BROADCAST_EN
    if (stimBcast) begin
      for (int i = 0; i < numOut(k); i++)
        if (modelHas[k][i] && !stimReady[i]) return 1'b0;
      return 1'b1;
    end
`endif
    if (int'(stimSel) >= numOut(k)) return 1'b1;
    return !modelHas[k][stimSel] || stimReady[stimSel];
  endfunction

  function automatic logic [63:0] expValid(int k);
    logic [63:0] v = '0;
    for (int i = 0; i < numOut(k); i++) v[i] = modelHas[k][i];
    return v;
  endfunction

  function automatic logic [63:0] expData(int k);
    logic [63:0] d = '0;
    for (int i = 0; i < numOut(k); i++)
      if (modelHas[k][i]) d[i*16 +: 16] = modelWord[k][i];
    return d;
  endfunction

  function automatic logic [63:0] validMask(int k);
    logic [63:0] m = '0;
    for (int i = 0; i < numOut(k); i++)
      if (modelHas[k][i]) m[i*16 +: 16] = 16'hFFFF;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelStep(int k);
    bit acc = stimValid && modelReady(k);
    for (int i = 0; i < numOut(k); i++)
      if (modelHas[k][i] && stimReady[i]) modelHas[k][i] = 1'b0;
    if (!acc) return;
`ifdef DEMUX_BROADCAST_EN
    if (stimBcast) begin
      for (int i = 0; i < numOut(k); i++) begin
        modelHas[k][i]  = 1'b1;
        modelWord[k][i] = stimData[15:0];
      end
      return;
    end
`endif
    if (int'(stimSel) < numOut(k)) begin
      modelHas[k][stimSel]  = 1'b1;
      modelWord[k][stimSel] = stimData[15:0];
    end else if (modelDrops[k] < dropMax(k)) begin
      modelDrops[k]++;
    end
  endtask

  task automatic checkAll();
    checkOutput("A.in_ready",   64'(busA.in_ready),        64'(modelReady(0)));
    checkOutput("A.out_valid",  64'(busA.out_valid),       expValid(0));
    checkOutput("A.out_data",   busA.out_data & validMask(0), expData(0));
    checkOutput("A.drop_count", 64'(busA.drop_count),      64'(modelDrops[0]));
    checkOutput("B.in_ready",   64'(busB.in_ready),        64'(modelReady(1)));
    checkOutput("B.out_valid",  64'(busB.out_valid),       expValid(1));
    checkOutput("B.out_data",   64'(busB.out_data) & validMask(1), expData(1));
    checkOutput("B.drop_count", 64'(busB.drop_count),      64'(modelDrops[1]));
  endtask

  task automatic runCycle();
    @(negedge clock);
    checkAll();
    modelStep(0);
    modelStep(1);
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input logic [1:0] sel, input logic [31:0] data,
                               input bit bcast, input logic [3:0] ready);
    stimValid = valid;
    stimSel   = sel;
    stimData  = data;
    stimBcast = bcast;
    stimReady = ready;
    #1;
  endtask

  // Reset is asserted mid-cycle so it exercises the asynchronous path.
  task automatic doReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset A.out_valid",  64'(busA.out_valid),  64'd0);
    checkOutput("reset A.out_data",   busA.out_data,        64'd0);
    checkOutput("reset A.drop_count", 64'(busA.drop_count), 64'd0);
    checkOutput("reset B.out_valid",  64'(busB.out_valid),  64'd0);
    checkOutput("reset B.drop_count", 64'(busB.drop_count), 64'd0);
    for (int k = 0; k < 2; k++) begin
      modelDrops[k] = 0;
      for (int i = 0; i < 4; i++) begin
        modelHas[k][i]  = 1'b0;
        modelWord[k][i] = '0;
      end
    end
    stimValid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int dropExp[5];
    dropExp = '{1, 2, 3, 3, 3};
    $display("[TB] starting demux_stream bench");
    doReset();

    // Basic delivery with truncation to 16 bits.
    applyStimulus(1, 2'd2, 32'hDEAD_BEEF, 0, 4'hF);
    runCycle();
    checkOutput("basic valid", 64'(busA.out_valid), 64'h4);
    checkOutput("basic ch2",   64'(busA.out_data[47:32]), 64'hBEEF);
    applyStimulus(0, 2'd0, 32'h0, 0, 4'hF);
    runCycle();

    // Backpressure on channel 1, then simultaneous drain and reload.
    applyStimulus(1, 2'd1, 32'h11, 0, 4'b1101);
    runCycle();
    applyStimulus(1, 2'd1, 32'h22, 0, 4'b1101);
    checkOutput("bp stall ready", 64'(busA.in_ready), 64'd0);
    runCycle();
    runCycle();
    checkOutput("bp hold ch1", 64'(busA.out_data[31:16]), 64'h11);
    applyStimulus(1, 2'd1, 32'h22, 0, 4'hF);
    checkOutput("bp release ready", 64'(busA.in_ready), 64'd1);
    runCycle();
    checkOutput("bp swap valid", 64'(busA.out_valid[1]), 64'd1);
    checkOutput("bp swap ch1",   64'(busA.out_data[31:16]), 64'h22);

    // A stalled channel 0 must not block channel 3.
    applyStimulus(1, 2'd0, 32'h44, 0, 4'b1110);
    runCycle();
    applyStimulus(1, 2'd3, 32'h33, 0, 4'b1110);
    checkOutput("indep ready", 64'(busA.in_ready), 64'd1);
    runCycle();
    checkOutput("indep ch3", 64'(busA.out_data[63:48]), 64'h33);
    checkOutput("indep ch0", 64'(busA.out_data[15:0]),  64'h44);

    for (int w = 0; w < 8; w++) begin
      applyStimulus(1, 2'(w % 4), 32'h100 + 32'(w), 0, 4'hF);
      checkOutput("tput ready", 64'(busA.in_ready), 64'd1);
      runCycle();
      checkOutput("tput word", 64'(busA.out_data[(w % 4)*16 +: 16]), 64'h100 + 64'(w));
    end

    // Invalid selector on the 3-channel instance saturates a 2-bit counter.
    doReset();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1, 2'd3, 32'h55 + 32'(n), 0, 4'hF);
      checkOutput("drop ready", 64'(busB.in_ready), 64'd1);
      runCycle();
      checkOutput("drop count", 64'(busB.drop_count), 64'(dropExp[n]));
      checkOutput("drop valid", 64'(busB.out_valid),  64'd0);
    end

    doReset();
    applyStimulus(1, 2'd2, 32'h77, 0, 4'b1011);
    runCycle();
    applyStimulus(1, 2'd0, 32'hA5, 1, 4'b1011);
`ifdef DEMUX_BROADCAST_EN
    checkOutput("bcast blocked", 64'(busA.in_ready), 64'd0);
    runCycle();
    checkOutput("bcast none loaded", 64'(busA.out_valid), 64'h4);
    applyStimulus(1, 2'd0, 32'hA5, 1, 4'hF);
    runCycle();
    checkOutput("bcast valid", 64'(busA.out_valid), 64'hF);
    checkOutput("bcast data",  busA.out_data, {4{16'h00A5}});
`else
    checkOutput("no-bcast ready", 64'(busA.in_ready), 64'd1);
    runCycle();
    checkOutput("no-bcast valid", 64'(busA.out_valid), 64'h5);
    checkOutput("no-bcast ch0",   64'(busA.out_data[15:0]), 64'hA5);
`endif

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) doReset();
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      runCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
